cycle_sequencer: RTL

Timing and instruction-register controller for the CPU control unit. It generates the one-hot T-state (`o_Cycle_Step`) and machine-cycle (`o_Cycle_Count`) vectors that drive the X-group microcode decoders. It latches the fetched opcode and registers its one-hot X/Y/Z/P/Q fields, and it sequences HALT entry and wake-up. It sits between the memory bus and the X0..X3 decoders and closes the loop on their `o_Fetch` outputs.

---
 rtl/cycle_sequencer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/cycle_sequencer.sv
// cycle_sequencer: T-state / M-cycle timing generator and instruction register for the control
// unit. Produces one-hot step and cycle vectors, latches the opcode with its one-hot X/Y/Z/P/Q
// fields, and sequences HALT entry and wake-up. Only o_Conditions is combinational.
module cycle_sequencer (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Enable,
  input  logic       i_Fetch,
  input  logic       i_Halt_Req,
  input  logic       i_Wake,
  input  logic [7:0] i_Data_Bus,
  input  logic [3:0] i_Flags,
  output logic [3:0] o_Cycle_Step,
  output logic [7:0] o_Cycle_Count,
  output logic [7:0] o_Opcode,
  output logic [3:0] o_X,
  output logic [7:0] o_Y,
  output logic [7:0] o_Z,
  output logic [3:0] o_P,
  output logic [1:0] o_Q,
  output logic [3:0] o_Conditions,
  output logic       o_Active,
  output logic       o_Halted,
  output logic       o_Error
);

  typedef enum logic [0:0] {StRun, StHalt} state_e;

  state_e     state_q, state_d;
  logic [3:0] step_q, step_d;
  logic [7:0] count_q, count_d;
  logic [7:0] opcode_q, opcode_d;
  logic [3:0] x_q, x_d;
  logic [7:0] y_q, y_d;
  logic [7:0] z_q, z_d;
  logic [3:0] p_q, p_d;
  logic [1:0] q_q, q_d;
  logic       active_q, active_d;
  logic       halted_q, halted_d;
  logic       error_q, error_d;

  // Next-state: timing rotation, opcode load, HALT entry/exit and overflow detection
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    count_d  = count_q;
    opcode_d = opcode_q;
    active_d = active_q;
    halted_d = halted_q;
    error_d  = error_q;

    if (i_Enable) begin
      case (state_q)
        StRun: begin
          if (step_q[3]) begin
            step_d = 4'b0001;
            if (i_Fetch) begin
              count_d = 8'b0000_0001;
              if (i_Halt_Req) begin
                // HALT executes as a NOP so wake-up restarts with a clean fetch
                state_d  = StHalt;
                opcode_d = 8'h00;
                active_d = 1'b0;
                halted_d = 1'b1;
              end else begin
                opcode_d = i_Data_Bus;
              end
            end else if (count_q[7]) begin
              // Instruction ran past M8 without a fetch: saturate and flag
              error_d = 1'b1;
            end else begin
              count_d = {count_q[6:0], 1'b0};
            end
          end else begin
            step_d = {step_q[2:0], 1'b0};
          end
        end
        StHalt: begin
          // Step and count stay frozen at T1/M1 until woken
          if (i_Wake) begin
            state_d  = StRun;
            opcode_d = 8'h00;
            active_d = 1'b1;
            halted_d = 1'b0;
          end
        end
        default: state_d = StRun;
      endcase
    end
  end

  // Field decode from the next opcode so fields land on the same edge as the opcode
  always_comb begin
    x_d = 4'b0001 << opcode_d[7:6];
    y_d = 8'b0000_0001 << opcode_d[5:3];
    z_d = 8'b0000_0001 << opcode_d[2:0];
    p_d = 4'b0001 << opcode_d[5:4];
    q_d = 2'b01 << opcode_d[3];
  end

  // State register with synchronous reset taking priority over enable
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q  <= StRun;
      step_q   <= 4'b0001;
      count_q  <= 8'b0000_0001;
      opcode_q <= 8'h00;
      x_q      <= 4'b0001;
      y_q      <= 8'b0000_0001;
      z_q      <= 8'b0000_0001;
      p_q      <= 4'b0001;
      q_q      <= 2'b01;
      active_q <= 1'b1;
      halted_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      count_q  <= count_d;
      opcode_q <= opcode_d;
      x_q      <= x_d;
      y_q      <= y_d;
      z_q      <= z_d;
      p_q      <= p_d;
      q_q      <= q_d;
      active_q <= active_d;
      halted_q <= halted_d;
      error_q  <= error_d;
    end
  end

  // Condition flags: bit0 NZ, bit1 Z, bit2 NC, bit3 C from {Z,N,H,C}
  always_comb begin
    o_Conditions = {i_Flags[0], ~i_Flags[0], i_Flags[3], ~i_Flags[3]};
  end

  assign o_Cycle_Step  = step_q;
  assign o_Cycle_Count = count_q;
  assign o_Opcode      = opcode_q;
  assign o_X           = x_q;
  assign o_Y           = y_q;
  assign o_Z           = z_q;
  assign o_P           = p_q;
  assign o_Q           = q_q;
  assign o_Active      = active_q;
  assign o_Halted      = halted_q;
  assign o_Error       = error_q;

endmodule
